// File: rtl/onehot_req_sequencer_pkg.sv
// onehot_req_sequencer_pkg: shared constants for the one-hot request sequencer
package onehot_req_sequencer_pkg;
    localparam int N_CH_DEF = 8;
    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_OFFER = 1'b1;
endpackage

// File: rtl/onehot_req_sequencer_rr_pick.sv
// onehot_req_sequencer_rr_pick: picks the first pending channel at or after rr_ptr (or from 0 when fixed priority)
module onehot_req_sequencer_rr_pick
    import onehot_req_sequencer_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter bit RR_EN = 1'b1,
    localparam int W = $clog2(N_CH)
) (
    input  logic [0:N_CH-1] pend,
    input  logic [W-1:0]    rr_ptr,
    output logic [0:N_CH-1] grant,
    output logic [W-1:0]    idx
);
    logic found;
    logic [W-1:0] c;
    always_comb begin
        grant = '0;
        idx = '0;
        found = 1'b0;
        c = '0;
        for (int k = 0; k < N_CH; k++) begin
            c = W'(((RR_EN ? int'(rr_ptr) : 0) + k) % N_CH);
            if (!found && pend[c]) begin
                found = 1'b1;
                idx = c;
            end
        end
        grant[idx] = found;
    end
endmodule

// File: rtl/onehot_req_sequencer.sv
// onehot_req_sequencer: sticky request capture issued one at a time as a registered one-hot grant
module onehot_req_sequencer
    import onehot_req_sequencer_pkg::*;
#(
    parameter int N_CH = N_CH_DEF,
    parameter bit RR_EN = 1'b1,
    localparam int W = $clog2(N_CH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [0:N_CH-1] req,
    output logic [0:N_CH-1] d_out,
    output logic            valid,
    input  logic            ready,
    output logic [0:N_CH-1] pending,
    output logic            overrun
);
    logic state, state_next, accept;
    logic [0:N_CH-1] pend, d_q, d_next, clr, pick_grant;
    logic [W-1:0] rr_ptr, g_idx, pick_idx;

    onehot_req_sequencer_rr_pick #(.N_CH(N_CH), .RR_EN(RR_EN)) u_pick (
        .pend(pend),
        .rr_ptr(rr_ptr),
        .grant(pick_grant),
        .idx(pick_idx)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= ST_IDLE;
            pend <= '0;
            d_q <= '0;
            g_idx <= '0;
            rr_ptr <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_next;
            pend <= (pend & ~clr) | req;
            overrun <= |(req & pend & ~clr);
            d_q <= d_next;
            if (state == ST_IDLE) g_idx <= pick_idx;
            if (accept) rr_ptr <= (g_idx == W'(N_CH - 1)) ? '0 : g_idx + 1'b1;
        end
    end

    always_comb begin
        state_next = (state == ST_IDLE) ? ((|pend) ? ST_OFFER : ST_IDLE)
                                        : (ready ? ST_IDLE : ST_OFFER);
    end

    // an accepted grant clears its pend bit; a same-cycle req re-sets it
    always_comb begin
        valid = (state == ST_OFFER);
        d_out = d_q;
        pending = pend;
        accept = valid & ready;
        clr = accept ? d_q : '0;
        d_next = (state == ST_IDLE) ? pick_grant : (ready ? '0 : d_q);
    end
endmodule

// File: tb/tb_onehot_req_sequencer.sv
// tb_onehot_req_sequencer: directed and random checks of RR and fixed-priority instances against a behavioural model
module tb_onehot_req_sequencer;
    localparam int N = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic [0:N-1] req = '0;
    logic [0:N-1] dq [2];
    logic [0:N-1] pq [2];
    logic [1:0] vq, oq;
    int n_pass = 0;
    int n_tot = 0;

    bit mp [2][N];
    int mg [2];
    bit mv [2];
    int mptr [2];
    bit mo [2];

    always #5 clk = ~clk;

    onehot_req_sequencer #(.N_CH(N), .RR_EN(1'b1)) dut_rr (
        .clk(clk), .rst(rst), .req(req), .d_out(dq[0]), .valid(vq[0]),
        .ready(ready), .pending(pq[0]), .overrun(oq[0])
    );
    onehot_req_sequencer #(.N_CH(N), .RR_EN(1'b0)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .d_out(dq[1]), .valid(vq[1]),
        .ready(ready), .pending(pq[1]), .overrun(oq[1])
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic rst_dut();
        rst = 1'b1;
        req = '0;
        ready = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    // model: pending set per channel, one offered channel at a time, pointer moves past each accepted grant
    always @(posedge clk or posedge rst) begin
        bit acc, ov, found, c;
        bit np [N];
        int base, ch;
        if (rst) begin
            for (int u = 0; u < 2; u++) begin
                mv[u] = 0; mg[u] = 0; mptr[u] = 0; mo[u] = 0;
                for (int i = 0; i < N; i++) mp[u][i] = 0;
            end
        end else begin
            for (int u = 0; u < 2; u++) begin
                acc = mv[u] && ready;
                ov = 0;
                for (int i = 0; i < N; i++) begin
                    c = acc && (i == mg[u]);
                    if (req[i] && mp[u][i] && !c) ov = 1;
                    np[i] = (mp[u][i] && !c) || req[i];
                end
                if (!mv[u]) begin
                    base = (u == 0) ? mptr[u] : 0;
                    found = 0;
                    for (int k = 0; k < N; k++) begin
                        ch = (base + k) % N;
                        if (!found && mp[u][ch]) begin
                            found = 1; mg[u] = ch; mv[u] = 1;
                        end
                    end
                end else if (acc) begin
                    mv[u] = 0;
                    mptr[u] = (mg[u] + 1) % N;
                end
                mo[u] = ov;
                for (int i = 0; i < N; i++) mp[u][i] = np[i];
            end
        end
    end

    always @(negedge clk) begin
        logic [0:N-1] e, p;
        if (!rst) begin
            for (int u = 0; u < 2; u++) begin
                e = '0;
                if (mv[u]) e[mg[u]] = 1'b1;
                for (int i = 0; i < N; i++) p[i] = mp[u][i];
                chk(u == 0 ? "model_rr_valid" : "model_fp_valid", 32'(vq[u]), 32'(mv[u]));
                chk(u == 0 ? "model_rr_d_out" : "model_fp_d_out", 32'(dq[u]), 32'(e));
                chk(u == 0 ? "model_rr_pending" : "model_fp_pending", 32'(pq[u]), 32'(p));
                chk(u == 0 ? "model_rr_overrun" : "model_fp_overrun", 32'(oq[u]), 32'(mo[u]));
            end
        end
    end

    initial begin
        tick();
        rst_dut();
        chk("rst_valid", 32'(vq[0]), 0);
        chk("rst_d_out", 32'(dq[0]), 0);

        // single event: grant two cycles after req, gone after accept
        ready = 1'b1; req = 8'b0001_0000;
        tick(); req = '0;
        chk("se_pend", 32'(pq[0]), 32'h10);
        chk("se_nvalid", 32'(vq[0]), 0);
        tick();
        chk("se_valid", 32'(vq[0]), 1);
        chk("se_d_out", 32'(dq[0]), 32'h10);
        tick();
        chk("se_drop", 32'(vq[0]), 0);
        chk("se_pend0", 32'(pq[0]), 0);

        // round-robin ordering and pointer wrap
        rst_dut(); ready = 1'b1; req = 8'b1000_0001;
        tick(); req = '0;
        tick();
        chk("rr_g1", 32'(dq[0]), 32'h80);
        tick(); tick();
        chk("rr_g2", 32'(dq[0]), 32'h01);
        tick(); req = 8'b1000_0001;
        tick(); req = '0;
        tick();
        chk("rr_p0_g1", 32'(dq[0]), 32'h80);
        tick(); tick();
        chk("rr_p0_g2", 32'(dq[0]), 32'h01);
        tick(); req = 8'b1000_0000;
        tick(); req = '0;
        tick(); tick(); req = 8'b1000_0001;
        tick(); req = '0;
        tick();
        chk("rr_p1_g1", 32'(dq[0]), 32'h01);
        tick(); tick();
        chk("rr_p1_g2", 32'(dq[0]), 32'h80);
        tick();

        // fixed priority: lowest index first
        rst_dut(); ready = 1'b1; req = 8'b0010_0100;
        tick(); req = '0;
        tick();
        chk("fp_g1", 32'(dq[1]), 32'h20);
        tick(); tick();
        chk("fp_g2", 32'(dq[1]), 32'h04);
        tick();

        // backpressure holds the grant; new events accumulate
        rst_dut(); req = 8'b0001_0000;
        tick(); req = '0;
        tick();
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(vq[0]), 1);
            chk("bp_d_out", 32'(dq[0]), 32'h10);
            req = (i == 1) ? 8'b0000_0100 : 8'b0;
            tick();
        end
        req = '0;
        chk("bp_pend", 32'(pq[0]), 32'h14);
        ready = 1'b1;
        tick();
        chk("bp_acc", 32'(vq[0]), 0);
        tick();
        chk("bp_next", 32'(dq[0]), 32'h04);
        tick();

        // overrun pulse and same-cycle re-request
        rst_dut(); req = 8'b0010_0000;
        tick(); req = '0;
        tick(); req = 8'b0010_0000;
        tick(); req = '0;
        chk("ov_pulse", 32'(oq[0]), 1);
        tick();
        chk("ov_clear", 32'(oq[0]), 0);
        ready = 1'b1; req = 8'b0010_0000;
        tick(); req = '0;
        chk("rq_pend", 32'(pq[0]), 32'h20);
        chk("rq_ov", 32'(oq[0]), 0);
        chk("rq_nvalid", 32'(vq[0]), 0);
        tick();
        chk("rq_valid", 32'(vq[0]), 1);
        chk("rq_d_out", 32'(dq[0]), 32'h20);
        tick();

        // asynchronous reset mid-offer
        rst_dut(); req = 8'b0110_0000;
        tick(); req = '0;
        tick(); req = 8'b0110_0000;
        tick(); req = '0;
        chk("ar_pre_valid", 32'(vq[0]), 1);
        chk("ar_pre_ov", 32'(oq[0]), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_valid", 32'(vq[0]), 0);
        chk("ar_d_out", 32'(dq[0]), 0);
        chk("ar_pending", 32'(pq[0]), 0);
        chk("ar_overrun", 32'(oq[0]), 0);
        tick(); rst = 1'b0;
        tick(); tick();
        chk("ar_post_valid", 32'(vq[0]), 0);
        chk("ar_post_pending", 32'(pq[0]), 0);

        // random traffic checked by the model every cycle
        rst_dut();
        for (int t = 0; t < 400; t++) begin
            for (int i = 0; i < N; i++) req[i] = ($urandom_range(0, 5) == 0);
            ready = 1'($urandom_range(0, 1));
            tick();
        end
        req = '0;
        tick();
        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end
endmodule
